// File: rtl/pe_mult_feed.sv
// pe_mult_feed: multiplies int16 operand pairs and packs the 32-bit products into a 32-lane vector held under valid/ready.
// Define PE_MULT_SIGNED_EN for two's-complement operands; the default build multiplies unsigned operands.
module pe_mult_feed (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   in_a,
    input  logic [15:0]   in_b,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [1023:0] mult_result,
    output logic [5:0]    out_lanes
);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]    r_state;
    logic [4:0]    r_idx;
    logic          r_out_valid;
    logic [5:0]    r_out_lanes;
    logic [1023:0] r_lanes;

    logic          w_accept;
    logic          w_close;
    logic [31:0]   w_prod;

    // in_ready depends only on state and reset, never on out_ready
    assign in_ready = !rst && (r_state == ST_FILL);
    assign w_accept = in_valid && in_ready;
    assign w_close  = (r_idx == 5'd31) || in_last;

`ifdef PE_MULT_SIGNED_EN
    assign w_prod = $signed(in_a) * $signed(in_b);
`else
    assign w_prod = {16'd0, in_a} * {16'd0, in_b};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_FILL;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_lanes <= '0;
            r_lanes     <= '0;
        end else if (r_state == ST_FILL) begin
            if (w_accept) begin
                r_lanes[{r_idx, 5'd0} +: 32] <= w_prod;
                r_idx <= r_idx + 5'd1;
                if (w_close) begin
                    r_state     <= ST_HOLD;
                    r_out_valid <= 1'b1;
                    r_out_lanes <= {1'b0, r_idx} + 6'd1;
                end
            end
        end else begin
            if (r_out_valid && out_ready) begin
                r_state     <= ST_FILL;
                r_idx       <= '0;
                r_out_valid <= 1'b0;
                r_out_lanes <= '0;
                r_lanes     <= '0;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_lanes   = r_out_lanes;
    assign mult_result = r_lanes;

endmodule

// File: tb/tb_pe_mult_feed.sv
// Self-checking bench for pe_mult_feed: randomized pairs checked against a queue-of-products model.
module tb_pe_mult_feed;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   in_a;
    logic [15:0]   in_b;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [1023:0] mult_result;
    logic [5:0]    out_lanes;

    int errors = 0;
    int checks = 0;
    logic [31:0] model_q[$];

    pe_mult_feed dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .mult_result(mult_result), .out_lanes(out_lanes)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_prod(input logic [15:0] a, input logic [15:0] b);
`ifdef PE_MULT_SIGNED_EN
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        return 32'(sa * sb);
`else
        longint ua;
        longint ub;
        ua = longint'(a);
        ub = longint'(b);
        return 32'(ua * ub);
`endif
    endfunction

    function automatic logic [1023:0] exp_vec();
        logic [1023:0] v;
        v = '0;
        foreach (model_q[i]) v[32*i +: 32] = model_q[i];
        return v;
    endfunction

    function automatic int bad_lane(input logic [1023:0] got, input logic [1023:0] want);
        for (int j = 0; j < 32; j++)
            if (got[32*j +: 32] !== want[32*j +: 32]) return j;
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [15:0] a, input logic [15:0] b, input logic last);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        tick();
        model_q.push_back(model_prod(a, b));
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_a     = 16'($urandom);
        in_b     = 16'($urandom);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        model_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready_low: got %b want 0", in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready_first: got %b want 1", in_ready);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || out_lanes !== 6'd0 || mult_result !== '0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_idle: got valid=%b lanes=%0d ready=%b nonzero=%b want valid=0 lanes=0 ready=1 nonzero=0",
                         out_valid, out_lanes, in_ready, |mult_result);
            end
        end
    endtask

    task automatic test_full_vector();
        logic [1023:0] want;
        out_ready = 1'b1;
        for (int j = 0; j < 32; j++) begin
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL full_fill_state: got ready=%b valid=%b want ready=1 valid=0 at pair %0d", in_ready, out_valid, j);
            end
            push_pair(16'(j + 1), 16'd2, 1'b0);
        end
        want = '0;
        for (int j = 0; j < 32; j++) want[32*j +: 32] = 32'(2 * (j + 1));
        checks++;
        if (out_valid !== 1'b1 || out_lanes !== 6'd32 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_close: got valid=%b lanes=%0d ready=%b want valid=1 lanes=32 ready=0", out_valid, out_lanes, in_ready);
        end
        checks++;
        if (mult_result !== want) begin
            errors++;
            $display("FAIL full_lanes: lane %0d got %h want %h", bad_lane(mult_result, want),
                     mult_result[32*bad_lane(mult_result, want) +: 32], want[32*bad_lane(mult_result, want) +: 32]);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || mult_result !== '0 || out_lanes !== 6'd0) begin
            errors++;
            $display("FAIL full_accept: got valid=%b ready=%b lanes=%0d nonzero=%b want 0/1/0/0", out_valid, in_ready, out_lanes, |mult_result);
        end
        out_ready = 1'b0;
        model_q.delete();
    endtask

    task automatic test_early_close();
        logic [1023:0] want;
        push_pair(16'd7, 16'd3, 1'b0);
        push_pair(16'd5, 16'd5, 1'b0);
        push_pair(16'd1, 16'd9, 1'b1);
        want = '0;
        want[31:0]  = 32'd21;
        want[63:32] = 32'd25;
        want[95:64] = 32'd9;
        checks++;
        if (out_valid !== 1'b1 || out_lanes !== 6'd3) begin
            errors++;
            $display("FAIL early_close: got valid=%b lanes=%0d want valid=1 lanes=3", out_valid, out_lanes);
        end
        checks++;
        if (mult_result !== want) begin
            errors++;
            $display("FAIL early_lanes: lane %0d got %h want %h", bad_lane(mult_result, want),
                     mult_result[32*bad_lane(mult_result, want) +: 32], want[32*bad_lane(mult_result, want) +: 32]);
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [1023:0] want;
        for (int j = 0; j < 32; j++) push_pair(16'($urandom), 16'($urandom), 1'b0);
        want = exp_vec();
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_a    = 16'($urandom);
            in_b    = 16'($urandom);
            in_last = 1'($urandom);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_lanes !== 6'd32 || mult_result !== want) begin
                errors++;
                $display("FAIL hold_stable: cycle %0d got ready=%b valid=%b lanes=%0d lane%0d=%h want ready=0 valid=1 lanes=32 lane=%h",
                         c, in_ready, out_valid, out_lanes, bad_lane(mult_result, want),
                         mult_result[32*bad_lane(mult_result, want) +: 32], want[32*bad_lane(mult_result, want) +: 32]);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || mult_result !== '0 || out_lanes !== 6'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: got valid=%b lanes=%0d ready=%b nonzero=%b want 0/0/1/0", out_valid, out_lanes, in_ready, |mult_result);
        end
        tick();
        checks++;
        if (mult_result !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_no_consume: got valid=%b nonzero=%b want valid=0 nonzero=0", out_valid, |mult_result);
        end
        model_q.delete();
    endtask

    task automatic test_corner_product();
        logic [31:0] want;
`ifdef PE_MULT_SIGNED_EN
        want = 32'hFFFF_FFFE;
`else
        want = 32'h0001_FFFE;
`endif
        push_pair(16'hFFFF, 16'h0002, 1'b1);
        checks++;
        if (mult_result[31:0] !== want || mult_result[1023:32] !== '0 || out_lanes !== 6'd1) begin
            errors++;
            $display("FAIL corner_product: got lane0=%h lanes=%0d want lane0=%h lanes=1", mult_result[31:0], out_lanes, want);
        end
        drain();
    endtask

    task automatic test_reset_midfill();
        logic [1023:0] want;
        for (int j = 0; j < 10; j++) push_pair(16'($urandom), 16'($urandom), 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_q.delete();
        push_pair(16'($urandom), 16'($urandom), 1'b1);
        want = exp_vec();
        checks++;
        if (out_valid !== 1'b1 || out_lanes !== 6'd1 || mult_result !== want) begin
            errors++;
            $display("FAIL reset_midfill: got valid=%b lanes=%0d lane0=%h upper_nonzero=%b want valid=1 lanes=1 lane0=%h upper_nonzero=0",
                     out_valid, out_lanes, mult_result[31:0], |mult_result[1023:32], want[31:0]);
        end
        drain();
    endtask

    task automatic test_random();
        logic [1023:0] want;
        int n;
        for (int v = 0; v < 12; v++) begin
            n = (v == 0) ? 32 : int'($urandom_range(1, 32));
            for (int i = 0; i < n; i++) begin
                for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
                    in_a    = 16'($urandom);
                    in_b    = 16'($urandom);
                    in_last = 1'($urandom);
                    tick();
                end
                in_last = 1'b0;
                push_pair(16'($urandom), 16'($urandom), (i == n - 1) ? ((n == 32) ? 1'($urandom) : 1'b1) : 1'b0);
            end
            want = exp_vec();
            for (int w = int'($urandom_range(0, 3)); w >= 0; w--) begin
                checks++;
                if (out_valid !== 1'b1 || out_lanes !== 6'(n) || mult_result !== want || in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL random_vec%0d: got valid=%b lanes=%0d lane%0d=%h want valid=1 lanes=%0d lane=%h",
                             v, out_valid, out_lanes, bad_lane(mult_result, want),
                             mult_result[32*bad_lane(mult_result, want) +: 32], n, want[32*bad_lane(mult_result, want) +: 32]);
                end
                if (w > 0) tick();
            end
            drain();
            checks++;
            if (out_valid !== 1'b0 || mult_result !== '0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL random_clear%0d: got valid=%b ready=%b nonzero=%b want 0/1/0", v, out_valid, in_ready, |mult_result);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_full_vector();
        test_early_close();
        test_backpressure();
        test_corner_product();
        test_reset_midfill();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
